qam_sym_upsampler: RTL
======================

QAM_SYM_UPSAMPLER -- requirements
Module: qam_sym_upsampler

Interface
REQ-001 SHALL have parameter SPS, default 4, samples per symbol; legal 2..16.
REQ-002 SHALL have parameter OUT_W, default 12, signed output sample width; legal 8..16.
REQ-003 SHALL have parameter ZERO_STUFF, default 1: 1 = zero-insert between symbols, 0 = sample-hold.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port mode  input  2  00 QPSK, 01 16-QAM, 10 64-QAM, 11 treated as 16-QAM.
REQ-007 SHALL have port src_sel  input  1  0 = external s_data stream, 1 = internal PRBS-15.
REQ-008 SHALL have port s_data  input  6  external symbol bits, LSB-aligned.
REQ-009 SHALL have port s_valid  input  1  s_data valid.
REQ-010 SHALL have port s_ready  output  1  symbol accepted when s_valid & s_ready.
REQ-011 SHALL have port m_i  output  OUT_W  signed I sample.
REQ-012 SHALL have port m_q  output  OUT_W  signed Q sample.
REQ-013 SHALL have port m_valid  output  1  m_i/m_q valid.
REQ-014 SHALL have port m_ready  input  1  downstream accepts sample when m_valid & m_ready.
REQ-015 SHALL have port m_sym_start  output  1  high on the first sample of each symbol.
REQ-016 SHALL have port underflow_cnt  output  16  saturating count of external-mode underflows.

Function
REQ-017 SHALL implement states IDLE and RUN plus phase counter 0..SPS-1; output register advances only when m_ready or !m_valid (stall otherwise: outputs, phase, LFSR, state frozen).
REQ-018 SHALL, at each symbol boundary (IDLE, or RUN with phase SPS-1 and advancing), load a new symbol: phase <= 0, m_sym_start <= 1, mode latched for that symbol.
REQ-019 SHALL drive s_ready = !src_sel & (state==IDLE | (phase==SPS-1 & m_ready)); s_ready always 0 in PRBS mode.
REQ-020 SHALL present an accepted external symbol on m_i/m_q with m_valid=1 on the cycle after the handshake (latency 1).
REQ-021 SHALL on phases 1..SPS-1 output 0/0 when ZERO_STUFF=1, or repeat the phase-0 values when ZERO_STUFF=0; m_sym_start=0.
REQ-022 SHALL map per axis, Gray coded: QPSK I=bit0, Q=bit1, 0->-1, 1->+1.
REQ-023 SHALL map 16-QAM I=bits[1:0], Q=bits[3:2]: 00->-3, 01->-1, 11->+1, 10->+3.
REQ-024 SHALL map 64-QAM I=bits[2:0], Q=bits[5:3]: 000->-7, 001->-5, 011->-3, 010->-1, 110->+1, 111->+3, 101->+5, 100->+7.
REQ-025 SHALL sign-extend mapped levels to OUT_W with no scaling; unused s_data bits ignored.
REQ-026 SHALL implement PRBS-15, seed 15'h7FFF, step: nb = s[14]^s[13], s <= {s[13:0], nb}; per symbol advance k steps in one cycle (k = 2/4/6 per mode), first generated bit = symbol bit 0.
REQ-027 SHALL in PRBS mode never stall except on m_ready; first symbol loaded on the first clock edge after reset release.
REQ-028 SHALL on external underflow (boundary reached, s_valid=0) go to IDLE, m_valid=0 next cycle, underflow_cnt +1 (saturate at 16'hFFFF); restart at phase 0 on next handshake.
REQ-029 SHALL apply src_sel and mode changes only at symbol boundaries; mid-symbol changes do not alter the current symbol.

Reset
REQ-030 SHALL on reset low immediately force: state IDLE, phase 0, m_i=m_q=0, m_valid=0, m_sym_start=0, s_ready=0, underflow_cnt=0, LFSR=15'h7FFF.
REQ-031 SHALL accept reset assertion at any point mid-symbol with no partial symbol emitted after release.

Verification
REQ-032 PRBS, mode=01, SPS=4, ZERO_STUFF=1, m_ready=1 -> first samples (-3,-3),(0,0),(0,0),(0,0); m_sym_start 1,0,0,0.
REQ-033 External, mode=10, s_data=6'b100000 handshake at cycle n -> cycle n+1 m_i=-7, m_q=+7, m_valid=1, m_sym_start=1.
REQ-034 m_ready low 3 cycles at phase 2 -> m_i/m_q/phase unchanged, s_ready=0; resumes at phase 3.
REQ-035 External, s_valid=0 at boundary -> m_valid=0 next cycle, underflow_cnt 0->1; next handshake restarts phase 0.
REQ-036 Mode QPSK->64-QAM at phase 2, ZERO_STUFF=0 -> current symbol held at +/-1 through phase 3; next symbol uses 64-QAM levels.
REQ-037 Reset pulse mid-symbol in PRBS mode -> outputs 0 same cycle; after release sequence repeats REQ-032 exactly.

Source files
------------

// File: rtl/qam_sym_upsampler.sv
// QAM symbol mapper and upsampler: maps QPSK/16/64-QAM symbols from an external
// stream or an internal PRBS-15 onto I/Q levels, then emits SPS samples per symbol.
//
// state | meaning
// IDLE  | no symbol in flight; next advance loads a symbol if one is available
// RUN   | emitting samples of the current symbol, phase 0..SPS-1
module qam_sym_upsampler #(
  parameter int SPS        = 4,
  parameter int OUT_W      = 12,
  parameter int ZERO_STUFF = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    src_sel,
  input  logic [5:0]              s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [OUT_W-1:0] m_i,
  output logic signed [OUT_W-1:0] m_q,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_sym_start,
  output logic [15:0]             underflow_cnt
);

  localparam int PH_W = $clog2(SPS);
  localparam logic [PH_W-1:0] LAST = PH_W'(SPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_n;
  logic [PH_W-1:0]        phase, phase_n;
  logic [14:0]            lfsr, lfsr_n, lfsr_adv, walk;
  logic signed [OUT_W-1:0] m_i_n, m_q_n;
  logic                   m_valid_n, m_sym_start_n;
  logic [15:0]            underflow_cnt_n;
  logic [5:0]             prbs_bits, sym_bits;
  logic                   nb;
  int                     k;
  logic signed [3:0]      lvl_i, lvl_q;
  logic                   advance, at_boundary;

  function automatic logic signed [3:0] map_2(input logic b);
    return b ? 4'sd1 : -4'sd1;
  endfunction

  function automatic logic signed [3:0] map_4(input logic [1:0] b);
    case (b)
      2'b00:   return -4'sd3;
      2'b01:   return -4'sd1;
      2'b11:   return 4'sd1;
      default: return 4'sd3;
    endcase
  endfunction

  function automatic logic signed [3:0] map_8(input logic [2:0] b);
    case (b)
      3'b000:  return -4'sd7;
      3'b001:  return -4'sd5;
      3'b011:  return -4'sd3;
      3'b010:  return -4'sd1;
      3'b110:  return 4'sd1;
      3'b111:  return 4'sd3;
      3'b101:  return 4'sd5;
      default: return 4'sd7;
    endcase
  endfunction

  // Unroll up to six LFSR steps; the state after k steps is what gets committed.
  always_comb begin
    case (mode)
      2'b00:   k = 2;
      2'b10:   k = 6;
      default: k = 4;
    endcase
    walk      = lfsr;
    lfsr_adv  = lfsr;
    prbs_bits = '0;
    nb        = 1'b0;
    for (int j = 0; j < 6; j++) begin
      nb           = walk[14] ^ walk[13];
      prbs_bits[j] = nb;
      walk         = {walk[13:0], nb};
      if (j == k - 1) lfsr_adv = walk;
    end
  end

  always_comb begin
    sym_bits = src_sel ? prbs_bits : s_data;
    case (mode)
      2'b00: begin
        lvl_i = map_2(sym_bits[0]);
        lvl_q = map_2(sym_bits[1]);
      end
      2'b10: begin
        lvl_i = map_8(sym_bits[2:0]);
        lvl_q = map_8(sym_bits[5:3]);
      end
      default: begin
        lvl_i = map_4(sym_bits[1:0]);
        lvl_q = map_4(sym_bits[3:2]);
      end
    endcase
  end

  assign advance     = m_ready | ~m_valid;
  assign at_boundary = (state == IDLE) | (phase == LAST);
  assign s_ready     = reset & ~src_sel & ((state == IDLE) | ((phase == LAST) & m_ready));

  always_comb begin
    state_n         = state;
    phase_n         = phase;
    lfsr_n          = lfsr;
    m_i_n           = m_i;
    m_q_n           = m_q;
    m_valid_n       = m_valid;
    m_sym_start_n   = m_sym_start;
    underflow_cnt_n = underflow_cnt;
    if (advance) begin
      if (at_boundary) begin
        if (src_sel || s_valid) begin
          state_n       = RUN;
          phase_n       = '0;
          m_i_n         = {{(OUT_W-4){lvl_i[3]}}, lvl_i};
          m_q_n         = {{(OUT_W-4){lvl_q[3]}}, lvl_q};
          m_valid_n     = 1'b1;
          m_sym_start_n = 1'b1;
          if (src_sel) lfsr_n = lfsr_adv;
        end else begin
          state_n       = IDLE;
          phase_n       = '0;
          m_i_n         = '0;
          m_q_n         = '0;
          m_valid_n     = 1'b0;
          m_sym_start_n = 1'b0;
          // Only a running stream that runs dry counts; idling from reset does not.
          if (state == RUN && underflow_cnt != 16'hFFFF)
            underflow_cnt_n = underflow_cnt + 16'd1;
        end
      end else begin
        phase_n       = phase + 1'b1;
        m_sym_start_n = 1'b0;
        if (ZERO_STUFF != 0) begin
          m_i_n = '0;
          m_q_n = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      phase         <= '0;
      lfsr          <= 15'h7FFF;
      m_i           <= '0;
      m_q           <= '0;
      m_valid       <= 1'b0;
      m_sym_start   <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      lfsr          <= lfsr_n;
      m_i           <= m_i_n;
      m_q           <= m_q_n;
      m_valid       <= m_valid_n;
      m_sym_start   <= m_sym_start_n;
      underflow_cnt <= underflow_cnt_n;
    end
  end

endmodule
